mul_sequencer: RTL and testbench
================================

MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; no other clock or reset SHALL exist.
REQ-002 The port clk SHALL be an input, 1 bit wide, and serve as the clock; all state SHALL update on its rising edge.
REQ-003 The port rst SHALL be an input, 1 bit wide, and serve as the asynchronous active-high reset.
REQ-004 The port start SHALL be an input, 1 bit wide: it requests a multiply and is sampled only when the block is not busy.
REQ-005 The port flush SHALL be an input, 1 bit wide: a synchronous cancel of any operation in flight.
REQ-006 The port sign SHALL be an input, 1 bit wide: 1 selects a two's-complement multiply and 0 selects unsigned; it is latched with start.
REQ-007 The ports opA and opB SHALL be inputs, 16 bits wide each, carrying the multiplicand and multiplier; they are latched with start.
REQ-008 The port busy SHALL be an output, 1 bit wide, asserted while the block is in the RUN or FIX state.
REQ-009 The port done SHALL be an output, 1 bit wide, asserted for exactly one cycle while the block is in the DONE state.
REQ-010 The ports prodHi and prodLo SHALL be outputs, 16 bits wide each, together forming the 32-bit product register.
REQ-011 The port ovf SHALL be an output, 1 bit wide: 1 when the product does not fit in 16 bits for the selected signedness.

Function
REQ-012 The FSM SHALL have exactly four states, IDLE, RUN, FIX and DONE, with IDLE as the reset state.
REQ-013 In IDLE or DONE, start=1 with flush=0 SHALL latch the operands and the sign flag, clear the 4-bit iteration counter and move the FSM to RUN.
REQ-014 At latch time with sign=1, the block SHALL store abs(opA) and abs(opB) and record neg = opA[15] XOR opB[15]; with sign=0, neg SHALL be 0.
REQ-015 Each RUN cycle SHALL add the multiplicand to the 17-bit upper accumulator when the multiplier LSB is 1, shift {carry, acc, mq} right by one bit, and increment the counter.
REQ-016 After counter value 15, RUN SHALL go to FIX when neg=1, and to DONE otherwise.
REQ-017 FIX SHALL take one cycle to two's-complement negate the 32-bit accumulated result, then go to DONE.
REQ-018 {prodHi, prodLo} and ovf SHALL be written only on entry to DONE and SHALL hold their values until the next entry to DONE or a reset.
REQ-019 ovf SHALL be prodHi != 0 for an unsigned multiply, and prodHi != {16{prodLo[15]}} for a signed multiply.
REQ-020 DONE SHALL last one cycle and then go to IDLE, unless start=1 is accepted there per REQ-013.
REQ-021 The latency from the start-sampling edge to done SHALL be 17 cycles when neg=0 and 18 cycles when neg=1.
REQ-022 start SHALL be ignored while busy=1, and the latched operands SHALL be unaffected by input changes during RUN or FIX.
REQ-023 flush=1 SHALL force the FSM to IDLE on the next edge from any state, with priority over start, and SHALL leave prodHi, prodLo and ovf unchanged.
REQ-024 The special signed operand 0x8000 SHALL be handled as magnitude 0x8000 (17-bit-safe), so that -32768*-32768 = 0x40000000.

Reset
REQ-025 rst=1 SHALL immediately, without waiting for a clock edge, force the FSM to IDLE, clear the counter, and set busy=0, done=0, prodHi=0, prodLo=0 and ovf=0, including mid-operation.
REQ-026 After rst is deasserted, the first start SHALL be accepted on the first clk edge at which it is high.

Verification
REQ-027 A bench SHALL apply start with sign=0, opA=3 and opB=5 and check done at +17 cycles with prodHi=0x0000, prodLo=0x000F and ovf=0.
REQ-028 A bench SHALL apply start with sign=0 and opA=opB=0xFFFF and check prodHi=0xFFFE, prodLo=0x0001 and ovf=1 at +17 cycles.
REQ-029 A bench SHALL apply start with sign=1, opA=0xFFFD (-3) and opB=5 and check done at +18 cycles with prodHi=0xFFFF, prodLo=0xFFF1 and ovf=0.
REQ-030 A bench SHALL pulse start with new operands at counter=7 and check that they are ignored and that the original product appears at the original cycle.
REQ-031 A bench SHALL assert flush at counter=7 and check IDLE next cycle, busy=0, no done pulse, and the prior product held.
REQ-032 A bench SHALL assert rst asynchronously mid-RUN and check that all outputs are 0 before the next clk edge, then that a fresh 3*5 completes normally.

Source files
------------

// File: rtl/mul_sequencer.sv
// ============================================================================
//  Module      : mul_sequencer
//  Description : 16x16 shift-add multiplier, signed or unsigned, with
//                flush, overflow flag and a held 32-bit product register.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mul_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        flush,
    input  logic        sign,
    input  logic [15:0] opA,
    input  logic [15:0] opB,
    output logic        busy,
    output logic        done,
    output logic [15:0] prodHi,
    output logic [15:0] prodLo,
    output logic        ovf
);

    localparam int unsigned W = 16;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]     state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   mq_q, mq_d;
    logic           neg_q, neg_d;
    logic           sgn_q, sgn_d;
    logic [2*W-1:0] prod_q, prod_d;
    logic           ovf_q, ovf_d;

    logic           w_accept;
    logic           w_last;
    logic [W-1:0]   w_abs_a;
    logic [W-1:0]   w_abs_b;
    logic [W-1:0]   w_addend;
    logic [W:0]     w_sum;
    logic [2*W-1:0] w_step;
    logic [2*W-1:0] w_neg;
    logic [2*W-1:0] w_res;
    logic           w_ovf;

    assign w_accept = ((state_q == S_IDLE) || (state_q == S_DONE)) && start && !flush;
    assign w_last   = (cnt_q == 4'd15);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; flush overrides everything
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (w_accept) state_d = S_RUN;
                S_RUN:   if (w_last)   state_d = neg_q ? S_FIX : S_DONE;
                S_FIX:   state_d = S_DONE;
                S_DONE:  state_d = w_accept ? S_RUN : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_RUN:   busy = 1'b1;
            S_FIX:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath. Magnitudes are 16-bit unsigned, so 0x8000 keeps its
    // full magnitude instead of wrapping back to a negative value.
    // ------------------------------------------------------------------
    assign w_abs_a  = (sign && opA[W-1]) ? (~opA + 16'd1) : opA;
    assign w_abs_b  = (sign && opB[W-1]) ? (~opB + 16'd1) : opB;
    assign w_addend = mq_q[0] ? mcand_q : '0;
    assign w_sum    = {1'b0, acc_q} + {1'b0, w_addend};
    assign w_step   = {w_sum, mq_q[W-1:1]};
    assign w_neg    = ~{acc_q, mq_q} + 32'd1;
    assign w_res    = (state_q == S_FIX) ? w_neg : w_step;
    assign w_ovf    = sgn_q ? (w_res[2*W-1:W] != {W{w_res[W-1]}})
                            : (w_res[2*W-1:W] != '0);

    always_comb begin
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        neg_d   = neg_q;
        sgn_d   = sgn_q;
        prod_d  = prod_q;
        ovf_d   = ovf_q;
        if (w_accept) begin
            mcand_d = w_abs_a;
            mq_d    = w_abs_b;
            acc_d   = '0;
            cnt_d   = 4'd0;
            neg_d   = sign & (opA[W-1] ^ opB[W-1]);
            sgn_d   = sign;
        end else if (!flush) begin
            case (state_q)
                S_RUN: begin
                    {acc_d, mq_d} = w_step;
                    cnt_d         = cnt_q + 4'd1;
                end
                S_FIX: begin
                    {acc_d, mq_d} = w_neg;
                end
                default: begin
                    cnt_d = cnt_q;
                end
            endcase
        end
        // Result register only changes on the transition into DONE
        if (state_d == S_DONE) begin
            prod_d = w_res;
            ovf_d  = w_ovf;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= 4'd0;
            mcand_q <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            neg_q   <= 1'b0;
            sgn_q   <= 1'b0;
            prod_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            neg_q   <= neg_d;
            sgn_q   <= sgn_d;
            prod_q  <= prod_d;
            ovf_q   <= ovf_d;
        end
    end

    assign prodHi = prod_q[2*W-1:W];
    assign prodLo = prod_q[W-1:0];
    assign ovf    = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_sequencer.sv
// ============================================================================
//  Module      : tb_mul_sequencer
//  Description : Directed and random checks of mul_sequencer against an
//                arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mul_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        flush;
    logic        sign;
    logic [15:0] opA;
    logic [15:0] opB;
    logic        busy;
    logic        done;
    logic [15:0] prodHi;
    logic [15:0] prodLo;
    logic        ovf;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [31:0] last_prod;
    logic        last_ovf;

    mul_sequencer dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .flush  (flush),
        .sign   (sign),
        .opA    (opA),
        .opB    (opB),
        .busy   (busy),
        .done   (done),
        .prodHi (prodHi),
        .prodLo (prodLo),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer multiply, range test for overflow
    function automatic void ref_mul(input logic [15:0] a, input logic [15:0] b, input logic s,
                                    output logic [31:0] p, output logic o, output int lat);
        longint r;
        if (s) begin
            r   = longint'($signed(a)) * longint'($signed(b));
            o   = (r > 32767) || (r < -32768);
            lat = (a[15] != b[15]) ? 18 : 17;
        end else begin
            r   = longint'(a) * longint'(b);
            o   = (r > 65535);
            lat = 17;
        end
        p = r[31:0];
    endfunction

    // Issue one multiply; optionally pulse start with other operands at counter=7
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                          input string tag, input bit poke);
        logic [31:0] ep;
        logic        eo;
        int          elat;
        int          n;
        ref_mul(a, b, s, ep, eo, elat);
        @(negedge clk);
        opA = a; opB = b; sign = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        opA = 16'($urandom); opB = 16'($urandom); sign = 1'($urandom);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
        n = 1;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (poke && n == 8) begin
                start = 1'b1; opA = 16'h7FFF; opB = 16'h7FFF; sign = 1'b0;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk({tag, "_latency"}, n, elat);
        chk({tag, "_prod"}, {prodHi, prodLo}, ep);
        chk({tag, "_ovf"}, {31'b0, ovf}, {31'b0, eo});
        @(posedge clk); #1;
        chk({tag, "_done_one_cycle"}, {31'b0, done}, 32'd0);
        last_prod = ep;
        last_ovf  = eo;
    endtask

    initial begin
        int seen;
        logic [15:0] ra, rb;
        rst = 1'b1; start = 1'b0; flush = 1'b0; sign = 1'b0; opA = '0; opB = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_prod", {prodHi, prodLo}, 32'd0);
        chk("reset_ovf",  {31'b0, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(16'd3,    16'd5,    1'b0, "u3x5", 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 1'b0, "uFFFFxFFFF", 1'b0);
        run_op(16'hFFFD, 16'd5,    1'b1, "sm3x5", 1'b0);
        run_op(16'h8000, 16'h8000, 1'b1, "s8000x8000", 1'b0);
        chk("s8000_value", {prodHi, prodLo}, 32'h4000_0000);
        run_op(16'h8000, 16'h0001, 1'b1, "s8000x1", 1'b0);
        run_op(16'h1234, 16'h0ABC, 1'b0, "start_ignored", 1'b1);

        // Flush at counter=7: back to IDLE, no done, product retained
        @(negedge clk);
        opA = 16'h4321; opB = 16'h00FF; sign = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", {31'b0, busy}, 32'd0);
        chk("flush_done", {31'b0, done}, 32'd0);
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) seen = 1;
        end
        chk("flush_no_done", seen, 0);
        chk("flush_prod_held", {prodHi, prodLo}, last_prod);
        chk("flush_ovf_held", {31'b0, ovf}, {31'b0, last_ovf});

        // Asynchronous reset mid-RUN
        @(negedge clk);
        opA = 16'h1234; opB = 16'h00FF; sign = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_done", {31'b0, done}, 32'd0);
        chk("arst_prod", {prodHi, prodLo}, 32'd0);
        chk("arst_ovf",  {31'b0, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(16'd3, 16'd5, 1'b0, "after_rst_3x5", 1'b0);

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0:       ra = 16'h8000;
                1:       ra = 16'($urandom_range(0, 3));
                default: ra = 16'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0:       rb = 16'hFFFF;
                1:       rb = 16'($urandom_range(0, 300));
                default: rb = 16'($urandom);
            endcase
            run_op(ra, rb, 1'($urandom), $sformatf("rand%0d", i), 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
